hidden_cpu_sequencer: RTL and testbench

HIDDEN_CPU_SEQUENCER -- requirements
Module: hidden_cpu_sequencer

---
 rtl/hidden_seq_pkg.sv | 36 +++
 rtl/hidden_seq_prog_mem.sv | 35 +++
 rtl/hidden_cpu_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_hidden_cpu_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hidden_seq_pkg.sv
// hidden_seq_pkg
// Shared definitions for the hidden CPU sequencer: instruction word layout
// {opcode[1:0], ra[1:0], rb[1:0]}, the default no-op word and the FSM state type.
// Ports: none (package).
package hidden_seq_pkg;

  localparam int OPCODE_W = 2;
  localparam int REG_W    = 2;
  localparam int INSTR_W  = OPCODE_W + 2 * REG_W;

  // Field positions inside an instruction word
  localparam int RB_LSB     = 0;
  localparam int RA_LSB     = REG_W;
  localparam int OPCODE_LSB = 2 * REG_W;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic logic [OPCODE_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_LSB +: OPCODE_W];
  endfunction

  function automatic logic [REG_W-1:0] instr_ra(input logic [INSTR_W-1:0] instr);
    return instr[RA_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] instr_rb(input logic [INSTR_W-1:0] instr);
    return instr[RB_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/hidden_seq_prog_mem.sv
// hidden_seq_prog_mem
// Program buffer: DEPTH x W storage, one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module hidden_seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 6,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage is deliberately left without reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hidden_cpu_sequencer.sv
// hidden_cpu_sequencer
// Loads a small program into a buffer while IDLE, then in RUN returns the
// word addressed by the core's program counter one cycle later. Running off
// the end of the loaded program moves to DONE; dropping start returns to IDLE.
// Optional watchdog: define HIDDEN_SEQ_WATCHDOG_EN to force DONE (with
// timeout=1) after WDOG_MAX+1 RUN cycles.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   load_valid    - load_data carries a program word
//   load_data     - program word {opcode, ra, rb}
//   load_ready    - buffer accepts a word this cycle (IDLE and not full)
//   start         - run request (level)
//   clear         - abort, empty the buffer, back to IDLE
//   pc_in         - program counter from the core
//   instr_out     - instruction to the core (NOP_INSTR when not valid)
//   instr_valid   - instr_out is a fetched program word
//   busy          - in RUN
//   done          - in DONE
//   timeout       - DONE was reached via the watchdog
module hidden_cpu_sequencer
  import hidden_seq_pkg::*;
#(
  parameter int                 DEPTH     = 16,
  parameter int                 WDOG_MAX  = 255,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  input  logic               start,
  input  logic               clear,
  input  logic [7:0]         pc_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Common width for comparing the 8-bit pc against the (AW+1)-bit word count
  localparam int CW = (AW + 1 > 8) ? AW + 1 : 8;

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] WONE    = (AW + 1)'(1);

  seq_state_e state, state_next;

  logic [AW:0]        wcount, wcount_next;
  logic [INSTR_W-1:0] instr_out_next;
  logic               instr_valid_next;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_rdata;
  logic [CW-1:0]      pc_ext, wcount_ext;
  logic               pc_hit;
  logic               wdog_fire;

`ifdef HIDDEN_SEQ_WATCHDOG_EN
  localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_MAX);
  logic [7:0] cyc, cyc_next;
  logic       timeout_q, timeout_next;
`else
  logic unused_wdog_max;
  assign unused_wdog_max = ^WDOG_MAX;
`endif

  hidden_seq_prog_mem #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wcount[AW-1:0]),
    .wdata (load_data),
    .raddr (pc_in[AW-1:0]),
    .rdata (mem_rdata)
  );

  // pc values at or past DEPTH always miss because wcount never exceeds DEPTH
  assign pc_ext     = CW'(pc_in);
  assign wcount_ext = CW'(wcount);
  assign pc_hit     = pc_ext < wcount_ext;

  assign load_ready = (state == ST_IDLE) && (wcount < DEPTH_W);
  assign busy       = (state == ST_RUN);
  assign done       = (state == ST_DONE);

`ifdef HIDDEN_SEQ_WATCHDOG_EN
  assign wdog_fire = (cyc == WDOG_LIMIT);
  assign timeout   = timeout_q;
`else
  assign wdog_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state and next register values; clear overrides everything
  always_comb begin
    state_next       = state;
    wcount_next      = wcount;
    instr_out_next   = NOP_INSTR;
    instr_valid_next = 1'b0;
    mem_we           = 1'b0;
`ifdef HIDDEN_SEQ_WATCHDOG_EN
    cyc_next         = cyc;
    timeout_next     = timeout_q;
`endif

    if (clear) begin
      state_next  = ST_IDLE;
      wcount_next = '0;
`ifdef HIDDEN_SEQ_WATCHDOG_EN
      cyc_next     = '0;
      timeout_next = 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // Any load_valid suppresses start, even when the buffer is full
          if (load_valid) begin
            if (load_ready) begin
              mem_we      = 1'b1;
              wcount_next = wcount + WONE;
            end
          end else if (start && (wcount != '0)) begin
            state_next = ST_RUN;
`ifdef HIDDEN_SEQ_WATCHDOG_EN
            cyc_next     = '0;
            timeout_next = 1'b0;
`endif
          end
        end

        ST_RUN: begin
`ifdef HIDDEN_SEQ_WATCHDOG_EN
          cyc_next = cyc + 8'd1;
`endif
          // Watchdog takes priority over the end-of-program check
          if (wdog_fire) begin
            state_next = ST_DONE;
`ifdef HIDDEN_SEQ_WATCHDOG_EN
            timeout_next = 1'b1;
`endif
          end else if (pc_hit) begin
            instr_out_next   = mem_rdata;
            instr_valid_next = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end

        ST_DONE: begin
          if (!start) begin
            state_next = ST_IDLE;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counters and registered instruction outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcount      <= '0;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
`ifdef HIDDEN_SEQ_WATCHDOG_EN
      cyc         <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      wcount      <= wcount_next;
      instr_out   <= instr_out_next;
      instr_valid <= instr_valid_next;
`ifdef HIDDEN_SEQ_WATCHDOG_EN
      cyc         <= cyc_next;
      timeout_q   <= timeout_next;
`endif
    end
  end

endmodule

// File: tb/tb_hidden_cpu_sequencer.sv
// tb_hidden_cpu_sequencer
// Self-checking bench for hidden_cpu_sequencer: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a behavioural model of the sequencer. Honors HIDDEN_SEQ_WATCHDOG_EN.
module tb_hidden_cpu_sequencer;

  localparam int         DEPTH    = 16;
  localparam int         WDOG_MAX = 255;
  localparam logic [5:0] NOP      = 6'h00;
`ifdef HIDDEN_SEQ_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [5:0] load_data;
  logic       load_ready;
  logic       start;
  logic       clear;
  logic [7:0] pc_in;
  logic [5:0] instr_out;
  logic       instr_valid;
  logic       busy;
  logic       done;
  logic       timeout;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  hidden_cpu_sequencer #(
    .DEPTH     (DEPTH),
    .WDOG_MAX  (WDOG_MAX),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .start       (start),
    .clear       (clear),
    .pc_in       (pc_in),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: program list, word count and run/finished flags
  logic [5:0] m_prog [DEPTH];
  int         m_count;
  int         m_runcyc;
  bit         m_busy, m_done, m_valid, m_timeout;
  logic [5:0] m_instr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_count   <= 0;
      m_runcyc  <= 0;
      m_instr   <= NOP;
      m_valid   <= 1'b0;
      m_timeout <= 1'b0;
    end else begin
      m_instr <= NOP;
      m_valid <= 1'b0;
      if (clear) begin
        m_busy    <= 1'b0;
        m_done    <= 1'b0;
        m_count   <= 0;
        m_timeout <= 1'b0;
      end else if (m_busy) begin
        m_runcyc <= m_runcyc + 1;
        if (WDOG_EN && (m_runcyc == WDOG_MAX)) begin
          m_busy    <= 1'b0;
          m_done    <= 1'b1;
          m_timeout <= 1'b1;
        end else if (int'(pc_in) < m_count) begin
          m_instr <= m_prog[pc_in[3:0]];
          m_valid <= 1'b1;
        end else begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end else if (m_done) begin
        if (!start) m_done <= 1'b0;
      end else begin
        if (load_valid) begin
          if (m_count < DEPTH) begin
            m_prog[m_count] <= load_data;
            m_count         <= m_count + 1;
          end
        end else if (start && (m_count > 0)) begin
          m_busy    <= 1'b1;
          m_runcyc  <= 0;
          m_timeout <= 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cmp_load_ready", int'(load_ready),
                  int'(!m_busy && !m_done && (m_count < DEPTH)));
      checkOutput("cmp_busy", int'(busy), int'(m_busy));
      checkOutput("cmp_done", int'(done), int'(m_done));
      checkOutput("cmp_timeout", int'(timeout), int'(m_timeout));
      checkOutput("cmp_instr_valid", int'(instr_valid), int'(m_valid));
      checkOutput("cmp_instr_out", int'(instr_out), int'(m_instr));
    end
  end

  // Inputs are sampled at the next rising edge; returns 2 time units after it
  task automatic applyStimulus(input logic lv, input logic [5:0] ld, input logic st,
                               input logic cl, input logic [7:0] pc);
    load_valid = lv;
    load_data  = ld;
    start      = st;
    clear      = cl;
    pc_in      = pc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    logic st_r;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    start      = 1'b0;
    clear      = 1'b0;
    pc_in      = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    checkOutput("rst_load_ready", int'(load_ready), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_timeout", int'(timeout), 0);
    checkOutput("rst_instr_valid", int'(instr_valid), 0);
    checkOutput("rst_instr_out", int'(instr_out), 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    // Start with an empty buffer is ignored
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("empty_start_busy", int'(busy), 0);
    // Load and start in the same cycle: the load wins
    applyStimulus(1, 6'h15, 1, 0, 0);
    checkOutput("load_start_busy", int'(busy), 0);
    applyStimulus(0, 0, 0, 1, 0);

    // Four-word program, pc walks 0..3 then runs off the end
    applyStimulus(1, 6'h11, 0, 0, 0);
    applyStimulus(1, 6'h22, 0, 0, 0);
    applyStimulus(1, 6'h33, 0, 0, 0);
    applyStimulus(1, 6'h04, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("run_entry_busy", int'(busy), 1);
    applyStimulus(0, 0, 1, 0, 8'd0);
    checkOutput("prog_pc0", int'(instr_out), 'h11);
    checkOutput("prog_pc0_valid", int'(instr_valid), 1);
    applyStimulus(0, 0, 1, 0, 8'd1);
    checkOutput("prog_pc1", int'(instr_out), 'h22);
    applyStimulus(0, 0, 1, 0, 8'd2);
    checkOutput("prog_pc2", int'(instr_out), 'h33);
    applyStimulus(0, 0, 1, 0, 8'd3);
    checkOutput("prog_pc3", int'(instr_out), 'h04);
    applyStimulus(0, 0, 1, 0, 8'd4);
    checkOutput("end_valid", int'(instr_valid), 0);
    checkOutput("end_instr", int'(instr_out), 0);
    checkOutput("end_done", int'(done), 1);
    checkOutput("end_timeout", int'(timeout), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drop_start_done", int'(done), 0);
    checkOutput("drop_start_ready", int'(load_ready), 1);

    // Fill the buffer; the 17th word is refused
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 6'(i + 'h20), 0, 0, 0);
    checkOutput("full_ready", int'(load_ready), 0);
    applyStimulus(1, 6'h3F, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 8'd15);
    checkOutput("full_pc15", int'(instr_out), 'h2F);
    applyStimulus(0, 0, 1, 0, 8'd16);
    checkOutput("full_pc16_done", int'(done), 1);
    applyStimulus(0, 0, 0, 0, 0);

    // One-word program with pc stuck at 0
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 6'h2A, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      n++;
      if (done) break;
    end
`ifdef HIDDEN_SEQ_WATCHDOG_EN
    checkOutput("wdog_cycles", n, 256);
    checkOutput("wdog_timeout", int'(timeout), 1);
    checkOutput("wdog_done", int'(done), 1);
`else
    checkOutput("nowdog_busy", int'(busy), 1);
    checkOutput("nowdog_done", int'(done), 0);
`endif

    // Clear in the middle of a run
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 6'h09, 0, 0, 0);
    applyStimulus(1, 6'h0A, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 8'd1);
    applyStimulus(0, 0, 1, 1, 8'd0);
    checkOutput("clear_busy", int'(busy), 0);
    checkOutput("clear_valid", int'(instr_valid), 0);
    checkOutput("clear_timeout", int'(timeout), 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("clear_empty_busy", int'(busy), 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a run
    applyStimulus(1, 6'h31, 0, 0, 0);
    applyStimulus(1, 6'h32, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 8'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", int'(busy), 0);
    checkOutput("arst_valid", int'(instr_valid), 0);
    checkOutput("arst_instr", int'(instr_out), 0);
    applyStimulus(0, 0, 1, 0, 8'd1);
    rst_n = 1'b1;
    applyStimulus(0, 0, 1, 0, 8'd1);
    checkOutput("arst_empty_busy", int'(busy), 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Randomized traffic checked by the every-cycle comparison
    st_r = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      logic       cl, lv;
      logic [7:0] pc;
      cl = ($urandom_range(0, 99) == 0);
      lv = (m_busy || m_done) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) st_r = !st_r;
      if ($urandom_range(0, 15) == 0) pc = 8'($urandom_range(0, 255));
      else pc = 8'($urandom_range(0, (m_count > 0) ? m_count + 2 : 2));
      applyStimulus(lv, 6'($urandom), st_r, cl, pc);
    end

    applyStimulus(0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
